slc3_key_conditioner: RTL

//   Input-conditioning stage directly upstream of the SLC-3 top level.

---
 rtl/slc3_key_conditioner.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/slc3_key_conditioner.sv
// Input conditioning for the SLC-3 top level: synchronizes the raw buttons and switches,
// debounces the keys into levels and press strobes, and builds the Run+Continue combo reset.

// Per-key debounce FSM operating on the synchronized, active-high key sample.
// state | meaning
// REL   | released, waiting for a press sample
// ARM   | press seen, counting stable pressed samples
// PRS   | press accepted, level high
// DIS   | release seen, counting stable released samples
module slc3_key_fsm #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk_sys,
  input  logic rst_b,
  input  logic k_s,
  output logic level,
  output logic pulse
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {REL, ARM, PRS, DIS} state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic            pulse_nxt;

  always_ff @(posedge clk_sys or negedge rst_b) begin
    if (!rst_b) begin
      state <= REL;
      cnt   <= '0;
      pulse <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      pulse <= pulse_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    pulse_nxt = 1'b0;
    case (state)
      REL: if (k_s) begin
        state_nxt = ARM;
        cnt_nxt   = CW'(1);
      end
      ARM: if (!k_s) begin
        state_nxt = REL;
        cnt_nxt   = '0;
      end else if (cnt == CNT_LAST) begin
        state_nxt = PRS;
        cnt_nxt   = '0;
        pulse_nxt = 1'b1;
      end else begin
        cnt_nxt = cnt + 1'b1;
      end
      PRS: if (!k_s) begin
        state_nxt = DIS;
        cnt_nxt   = CW'(1);
      end
      DIS: if (k_s) begin
        state_nxt = PRS;
        cnt_nxt   = '0;
      end else if (cnt == CNT_LAST) begin
        state_nxt = REL;
        cnt_nxt   = '0;
      end else begin
        cnt_nxt = cnt + 1'b1;
      end
      default: begin
        state_nxt = REL;
        cnt_nxt   = '0;
      end
    endcase
  end

  assign level = (state == PRS) || (state == DIS);
endmodule

module slc3_key_conditioner #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int COMBO_CYCLES    = 8,
  parameter int SW_W            = 10
) (
  input  logic            Clk,
  input  logic            Reset,
  input  logic            Run_key,
  input  logic            Continue_key,
  input  logic [SW_W-1:0] SW_raw,
  output logic [SW_W-1:0] SW_sync,
  output logic            Run_level,
  output logic            Continue_level,
  output logic            Run_pulse,
  output logic            Continue_pulse,
  output logic            Sys_reset_n
);
  localparam int CCW = $clog2(COMBO_CYCLES + 1);
  localparam logic [CCW-1:0] COMBO_MAX = CCW'(COMBO_CYCLES);

  logic [1:0]      run_sync, cont_sync;
  logic [SW_W-1:0] sw_meta;
  logic [CCW-1:0]  combo_cnt;
  logic            por_q;

  // Key synchronizers reset to the released (high) pin level.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      run_sync  <= 2'b11;
      cont_sync <= 2'b11;
      sw_meta   <= '0;
      SW_sync   <= '0;
    end else begin
      run_sync  <= {run_sync[0], Run_key};
      cont_sync <= {cont_sync[0], Continue_key};
      sw_meta   <= SW_raw;
      SW_sync   <= sw_meta;
    end
  end

  slc3_key_fsm #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_run_fsm (
    .clk_sys (Clk),
    .rst_b   (Reset),
    .k_s     (~run_sync[1]),
    .level   (Run_level),
    .pulse   (Run_pulse)
  );

  slc3_key_fsm #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_cont_fsm (
    .clk_sys (Clk),
    .rst_b   (Reset),
    .k_s     (~cont_sync[1]),
    .level   (Continue_level),
    .pulse   (Continue_pulse)
  );

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      combo_cnt <= '0;
      por_q     <= 1'b0;
    end else begin
      por_q <= 1'b1;
      if (!(Run_level && Continue_level))
        combo_cnt <= '0;
      else if (combo_cnt != COMBO_MAX)
        combo_cnt <= combo_cnt + 1'b1;
    end
  end

  // por_q holds the core in reset until the first edge after Reset releases.
  assign Sys_reset_n = por_q && (combo_cnt != COMBO_MAX);
endmodule
